// File: rtl/ws_inst_seq_pkg.sv
// Shared types and instruction-word layout for the weight-stationary sequencer.
// The idle word is the value that keeps both SRAMs deselected and the core quiet.
package ws_inst_seq_pkg;

   typedef enum logic [3:0] {
      IDLE,
      KFLUSH,
      W_L0,
      W_LOAD,
      A_L0,
      EXEC,
      DRAIN,
      OUT,
      DONE
   } state_e;

   localparam int B_KFLUSH   = 0;
   localparam int B_EXEC     = 1;
   localparam int B_L0_WR    = 2;
   localparam int B_L0_RD    = 3;
   localparam int B_OFIFO_RD = 6;
   localparam int B_A_XMEM   = 7;
   localparam int B_WEN_XMEM = 18;
   localparam int B_CEN_XMEM = 19;
   localparam int B_A_PMEM   = 20;
   localparam int B_WEN_PMEM = 31;
   localparam int B_CEN_PMEM = 32;
   localparam int B_OS_OR_WS = 38;

   localparam int IDLE_W = 57;
   localparam logic [IDLE_W-1:0] IDLE_WORD =
      (57'd1 << 40) | (57'd1 << 39) |
      (57'd1 << B_CEN_PMEM) | (57'd1 << B_WEN_PMEM) |
      (57'd1 << B_CEN_XMEM) | (57'd1 << B_WEN_XMEM);

endpackage

// File: rtl/ws_inst_seq_sram_rd_burst.sv
// SRAM read burst into L0: len_i reads at base_i+idx, with l0_wr trailing by one
// cycle to absorb the SRAM read latency. cnt_i counts down from len_i to 0.
module sram_rd_burst #(
   parameter int ADDR_W = 11,
   parameter int CNT_W  = 6
) (
   input  logic [ADDR_W-1:0] base_i,
   input  logic [CNT_W-1:0]  len_i,
   input  logic [CNT_W-1:0]  cnt_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              rd_o,
   output logic              wr_o
);

   logic [CNT_W-1:0] idx;

   assign idx    = len_i - cnt_i;
   assign addr_o = base_i + ADDR_W'(idx);
   assign rd_o   = (cnt_i != '0);
   assign wr_o   = (cnt_i != len_i);

endmodule

// File: rtl/ws_inst_seq.sv
// Weight-stationary instruction sequencer: per kernel position it flushes, loads
// weights, streams activations, executes, then drains the OFIFO into pmem.
//
// state  | meaning
// IDLE   | waiting for start
// KFLUSH | one-cycle kernel flush
// W_L0   | weight words xmem -> L0 (row reads + 1 latency cycle)
// W_LOAD | L0 -> PE weight load (row cycles)
// A_L0   | activation vectors xmem -> L0 (len_nij reads + 1 latency cycle)
// EXEC   | L0 -> array execute (len_nij cycles)
// DRAIN  | wait for first OFIFO row
// OUT    | OFIFO -> pmem, stalls on !ofifo_valid
// DONE   | one-cycle completion
module ws_inst_seq
   import ws_inst_seq_pkg::*;
#(
   parameter int row     = 8,
   parameter int len_nij = 36,
   parameter int ADDR_W  = 11,
   parameter int INST_W  = 57
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [3:0]        num_kij,
   input  logic [ADDR_W-1:0] w_base,
   input  logic [ADDR_W-1:0] act_base,
   input  logic [ADDR_W-1:0] psum_base,
   input  logic              ofifo_valid,
   output logic [INST_W-1:0] inst,
   output logic              busy,
   output logic              done,
   output logic [3:0]        kij_idx
);

   localparam int MAXL  = (row > len_nij) ? row : len_nij;
   localparam int CNT_W = $clog2(MAXL + 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  m_q, m_d;
   logic [3:0]        kij_q, kij_d;
   logic [3:0]        nk_q, nk_d;
   logic [ADDR_W-1:0] wb_q, wb_d, ab_q, ab_d, pb_q, pb_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic              busy_q, done_q;

   logic [ADDR_W-1:0] bst_base, bst_addr, pmem_addr;
   logic [CNT_W-1:0]  bst_len;
   logic              bst_rd, bst_wr;

   assign bst_base  = (state_q == A_L0) ? ab_q : wb_q + ADDR_W'(row) * ADDR_W'(kij_q);
   assign bst_len   = (state_q == A_L0) ? CNT_W'(len_nij) : CNT_W'(row);
   assign pmem_addr = pb_q + ADDR_W'(len_nij) * ADDR_W'(kij_q) + ADDR_W'(m_q);

   sram_rd_burst #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) u_burst (
      .base_i (bst_base),
      .len_i  (bst_len),
      .cnt_i  (cnt_q),
      .addr_o (bst_addr),
      .rd_o   (bst_rd),
      .wr_o   (bst_wr)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      m_d     = m_q;
      kij_d   = kij_q;
      nk_d    = nk_q;
      wb_d    = wb_q;
      ab_d    = ab_q;
      pb_d    = pb_q;
      inst_d  = INST_W'(IDLE_WORD);
      case (state_q)
         IDLE: begin
            if (start) begin
               if (num_kij != 4'd0) begin
                  nk_d    = num_kij;
                  wb_d    = w_base;
                  ab_d    = act_base;
                  pb_d    = psum_base;
                  kij_d   = 4'd0;
                  state_d = KFLUSH;
               end else begin
                  state_d = DONE;
               end
            end
         end
         KFLUSH: begin
            inst_d[B_KFLUSH] = 1'b1;
            cnt_d            = CNT_W'(row);
            state_d          = W_L0;
         end
         W_L0, A_L0: begin
            if (bst_rd) begin
               inst_d[B_CEN_XMEM]           = 1'b0;
               inst_d[B_A_XMEM +: ADDR_W]   = bst_addr;
            end
            inst_d[B_L0_WR] = bst_wr;
            if (cnt_q == '0) begin
               cnt_d   = (state_q == W_L0) ? CNT_W'(row - 1) : CNT_W'(len_nij - 1);
               state_d = (state_q == W_L0) ? W_LOAD : EXEC;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         W_LOAD, EXEC: begin
            inst_d[B_L0_RD] = 1'b1;
            inst_d[B_EXEC]  = (state_q == EXEC);
            if (cnt_q == '0) begin
               cnt_d   = CNT_W'(len_nij);
               state_d = (state_q == W_LOAD) ? A_L0 : DRAIN;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DRAIN: begin
            m_d = '0;
            if (ofifo_valid) state_d = OUT;
         end
         OUT: begin
            if (ofifo_valid) begin
               inst_d[B_OFIFO_RD]         = 1'b1;
               inst_d[B_CEN_PMEM]         = 1'b0;
               inst_d[B_WEN_PMEM]         = 1'b0;
               inst_d[B_A_PMEM +: ADDR_W] = pmem_addr;
               if (m_q == CNT_W'(len_nij - 1)) begin
                  m_d = '0;
                  if (kij_q != nk_q - 4'd1) begin
                     kij_d   = kij_q + 4'd1;
                     state_d = KFLUSH;
                  end else begin
                     state_d = DONE;
                  end
               end else begin
                  m_d = m_q + 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         m_q     <= '0;
         kij_q   <= '0;
         nk_q    <= '0;
         wb_q    <= '0;
         ab_q    <= '0;
         pb_q    <= '0;
         inst_q  <= INST_W'(IDLE_WORD);
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         m_q     <= m_d;
         kij_q   <= kij_d;
         nk_q    <= nk_d;
         wb_q    <= wb_d;
         ab_q    <= ab_d;
         pb_q    <= pb_d;
         inst_q  <= inst_d;
         busy_q  <= (state_d != IDLE);
         done_q  <= (state_q == DONE);
      end
   end

   assign inst    = inst_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign kij_idx = kij_q;

endmodule

// File: tb/tb_ws_inst_seq.sv
// Directed job sequence with randomized bases and OFIFO handshake, checked
// word-by-word against an expected instruction stream built from the job rules.
module tb_ws_inst_seq;

   localparam int ROW = 8;
   localparam int NIJ = 36;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  num_kij;
   logic [10:0] w_base, act_base, psum_base;
   logic        ofifo_valid;
   logic [56:0] inst;
   logic        busy, done;
   logic [3:0]  kij_idx;

   int n_checks = 0;
   int n_errors = 0;
   int pat_idx  = 0;
   int lat;

   always #5 clk = ~clk;

   ws_inst_seq dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .num_kij     (num_kij),
      .w_base      (w_base),
      .act_base    (act_base),
      .psum_base   (psum_base),
      .ofifo_valid (ofifo_valid),
      .inst        (inst),
      .busy        (busy),
      .done        (done),
      .kij_idx     (kij_idx)
   );

   function automatic logic [56:0] mk(input bit xr, input logic [10:0] xa, input bit l0wr,
                                      input bit l0rd, input bit ex, input bit kf,
                                      input bit pw, input logic [10:0] pa);
      logic [56:0] w;
      w = '0;
      w[40] = 1'b1; w[39] = 1'b1; w[32] = 1'b1; w[31] = 1'b1; w[19] = 1'b1; w[18] = 1'b1;
      if (xr) begin w[19] = 1'b0; w[17:7] = xa; end
      w[2] = l0wr; w[3] = l0rd; w[1] = ex; w[0] = kf;
      if (pw) begin w[32] = 1'b0; w[31] = 1'b0; w[30:20] = pa; w[6] = 1'b1; end
      return w;
   endfunction

   function automatic logic [56:0] w_idle();
      return mk(0, 11'd0, 0, 0, 0, 0, 0, 11'd0);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // mode 0: valid always 1 in DRAIN/OUT; 1: random everywhere; 2: repeating 1,0,0,1
   function automatic logic pick_v(input int mode);
      logic v;
      if (mode == 0) v = 1'b1;
      else if (mode == 1) v = ($urandom_range(0, 2) != 0);
      else begin
         v = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
         pat_idx++;
      end
      return v;
   endfunction

   task automatic run_job(input int nk, input logic [10:0] wb, input logic [10:0] ab,
                          input logic [10:0] pb, input int mode, input int abort_at,
                          input bit poke_start, output int latency);
      logic [56:0] q[$];
      logic [56:0] exp;
      logic        v;
      int          cyc, step, m, budget;
      bit          drained;
      cyc = 0; step = 0; latency = 0;
      pat_idx = 0;
      num_kij = 4'(nk); w_base = wb; act_base = ab; psum_base = pb;
      ofifo_valid = (mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_inst", inst, w_idle());
      chk("start_busy", busy, 1);
      chk("start_done", done, 0);
      for (int k = 0; k < nk; k++) begin
         q.delete();
         q.push_back(mk(0, 11'd0, 0, 0, 0, 1, 0, 11'd0));
         for (int i = 0; i <= ROW; i++)
            q.push_back(mk(i < ROW, 11'(wb + 11'(ROW * k + i)), i >= 1, 0, 0, 0, 0, 11'd0));
         for (int i = 0; i < ROW; i++) q.push_back(mk(0, 11'd0, 0, 1, 0, 0, 0, 11'd0));
         for (int j = 0; j <= NIJ; j++)
            q.push_back(mk(j < NIJ, 11'(ab + 11'(j)), j >= 1, 0, 0, 0, 0, 11'd0));
         for (int j = 0; j < NIJ; j++) q.push_back(mk(0, 11'd0, 0, 1, 1, 0, 0, 11'd0));
         foreach (q[i]) begin
            ofifo_valid = (mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
            step++;
            if (abort_at != 0 && step == abort_at) begin
               reset = 1'b1;
               @(posedge clk); #1;
               reset = 1'b0;
               chk("abort_inst", inst, w_idle());
               chk("abort_busy", busy, 0);
               chk("abort_done", done, 0);
               chk("abort_kij", kij_idx, 0);
               return;
            end
            @(posedge clk); cyc++; #1;
            chk("fixed_inst", inst, q[i]);
            chk("fixed_busy", busy, 1);
            chk("fixed_kij", kij_idx, 4'(k));
         end
         m = 0; drained = 0; budget = 0;
         while (m < NIJ && budget < 400) begin
            v = pick_v(mode);
            ofifo_valid = v;
            if (poke_start) start = ($urandom_range(0, 1) == 1);
            @(posedge clk); cyc++; #1;
            start = 1'b0;
            if (!drained) begin
               exp = w_idle();
               if (v) drained = 1;
            end else if (v) begin
               exp = mk(0, 11'd0, 0, 0, 0, 0, 1, 11'(pb + 11'(NIJ * k + m)));
               m++;
            end else begin
               exp = w_idle();
            end
            chk("out_inst", inst, exp);
            chk("out_busy", busy, 1);
            budget++;
         end
         if (m < NIJ) begin
            n_checks++; n_errors++;
            $display("FAIL out_timeout: wrote %0d rows, required %0d", m, NIJ);
            return;
         end
      end
      ofifo_valid = 1'b0;
      @(posedge clk); cyc++; #1;
      chk("end_done", done, 1);
      chk("end_inst", inst, w_idle());
      chk("end_busy", busy, 0);
      latency = cyc;
      @(posedge clk); #1;
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; num_kij = 4'd0; ofifo_valid = 1'b0;
      w_base = '0; act_base = '0; psum_base = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_inst", inst, w_idle());
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_kij", kij_idx, 0);
      reset = 1'b0;
      @(posedge clk); #1;

      // single kernel, valid from DRAIN onward; latency from start edge to done
      run_job(1, 11'd0, 11'd100, 11'd0, 0, 0, 0, lat);
      chk("done_latency", lat, 1 + 9 + 8 + 37 + 36 + 1 + 36 + 1);

      // empty job: done one edge after DONE is entered, no memory traffic
      num_kij = 4'd0; start = 1'b1; ofifo_valid = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("nk0_inst0", inst, w_idle());
      chk("nk0_done0", done, 0);
      @(posedge clk); #1;
      chk("nk0_done1", done, 1);
      chk("nk0_inst1", inst, w_idle());
      @(posedge clk); #1;
      chk("nk0_done2", done, 0);
      chk("nk0_busy2", busy, 0);
      ofifo_valid = 1'b0;

      run_job(3, 11'd0, 11'd100, 11'd0, 1, 0, 0, lat);
      run_job(2, 11'($urandom), 11'($urandom), 11'($urandom), 2, 0, 0, lat);

      // abort mid-EXEC, then a full job must run cleanly
      run_job(2, 11'd40, 11'd300, 11'd500, 1, 70, 0, lat);
      @(posedge clk); #1;
      chk("abort_idle_busy", busy, 0);
      run_job(2, 11'd40, 11'd300, 11'd500, 1, 0, 0, lat);

      // pmem and xmem wrap, start pokes during DRAIN/OUT
      run_job(1, 11'd2044, 11'd2030, 11'd2040, 1, 0, 1, lat);
      repeat (3) @(posedge clk);
      #1;
      chk("poke_idle_busy", busy, 0);

      for (int t = 0; t < 2; t++)
         run_job($urandom_range(1, 3), 11'($urandom), 11'($urandom), 11'($urandom), 1, 0, 0, lat);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
